isqrt_sched: RTL and testbench

//  Two-requester round-robin scheduler that shares one isqrt unit.
//  - Arbitrates between requesters and latches the winner's operand.
//  - Drives the isqrt start/operand pins and waits a fixed number of cycles.
//  - Returns the 4-bit root to the granted requester with a done pulse.
//  - Sits between the user-facing input logic and the single isqrt instance.

---
 rtl/isqrt_sched.sv | 115 +++++++++++
 tb/tb_isqrt_sched.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/isqrt_sched.sv
// isqrt_sched: two-requester round-robin front end for one shared isqrt unit.
// Grants a requester, runs the unit for a fixed wait window, returns the root.
module isqrt_sched #(
    parameter int WAIT_CYC = 40,
    parameter int CW       = 6
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       req0,
    input  logic [7:0] a0,
    input  logic       req1,
    input  logic [7:0] a1,
    output logic       ack0,
    output logic       ack1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] result,
    output logic       busy,
    output logic [7:0] sq_a,
    output logic       sq_start,
    input  logic [3:0] sq_sqrt
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [CW-1:0] CNT_LAST = CW'(WAIT_CYC - 1);

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          rr;
    logic          rr_nxt;
    logic          owner;
    logic          owner_nxt;
    logic [7:0]    sq_a_nxt;
    logic [3:0]    result_nxt;
    logic          win;

    // rr names the requester that wins the next tie; it flips away from
    // each winner so simultaneous requests alternate starting with 0.
    assign win = (req0 && req1) ? rr : req1;

    // State, counter, arbitration pointer and datapath registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state  <= S_IDLE;
            cnt    <= '0;
            rr     <= 1'b0;
            owner  <= 1'b0;
            sq_a   <= '0;
            result <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rr     <= rr_nxt;
            owner  <= owner_nxt;
            sq_a   <= sq_a_nxt;
            result <= result_nxt;
        end
    end

    // Next-state logic and state-decoded handshake outputs.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rr_nxt     = rr;
        owner_nxt  = owner;
        sq_a_nxt   = sq_a;
        result_nxt = result;
        ack0       = 1'b0;
        ack1       = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        sq_start   = 1'b0;
        busy       = (state != S_IDLE);
        unique case (state)
            S_IDLE: begin
                if (req0 || req1) begin
                    owner_nxt = win;
                    rr_nxt    = ~win;
                    sq_a_nxt  = win ? a1 : a0;
                    state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                sq_start  = 1'b1;
                ack0      = ~owner;
                ack1      = owner;
                cnt_nxt   = '0;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (cnt == CNT_LAST) begin
                    result_nxt = sq_sqrt;
                    state_nxt  = S_DONE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            S_DONE: begin
                done0     = ~owner;
                done1     = owner;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_isqrt_sched.sv
// tb_isqrt_sched: directed and randomized checks of isqrt_sched against a
// behavioural arbitration/timing model, with a variable-latency isqrt model.
module tb_isqrt_sched;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic       req0 = 1'b0;
    logic [7:0] a0 = '0;
    logic       req1 = 1'b0;
    logic [7:0] a1 = '0;
    logic       ack0, ack1, done0, done1;
    logic [3:0] result;
    logic       busy;
    logic [7:0] sq_a;
    logic       sq_start;
    logic [3:0] sq_sqrt;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    bit next_tie = 1'b0;

    isqrt_sched #(.WAIT_CYC(40), .CW(6)) dut (
        .clk(clk), .clr(clr),
        .req0(req0), .a0(a0), .req1(req1), .a1(a1),
        .ack0(ack0), .ack1(ack1), .done0(done0), .done1(done1),
        .result(result), .busy(busy),
        .sq_a(sq_a), .sq_start(sq_start), .sq_sqrt(sq_sqrt)
    );

    always #5 clk = ~clk;

    // Free-running cycle stamp for period measurements.
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [3:0] ref_isqrt(input logic [7:0] a);
        int r = 0;
        while ((r + 1) * (r + 1) <= int'(a)) r++;
        return 4'(r);
    endfunction

    // isqrt model: result appears a random number of cycles after start;
    // before that it shows the bitwise complement so an early capture is wrong.
    int         sq_lat = 0;
    logic [7:0] sq_op = '0;
    always @(posedge clk) begin
        if (sq_start) begin
            sq_op  <= sq_a;
            sq_lat <= int'($urandom_range(2, 38));
        end else if (sq_lat > 0) begin
            sq_lat <= sq_lat - 1;
        end
    end
    always_comb sq_sqrt = (sq_lat == 0) ? ref_isqrt(sq_op) : ~ref_isqrt(sq_op);

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Round-robin reference: tie goes to next_tie, which then moves away.
    function automatic bit model_grant(input bit r0, input bit r1);
        bit w = (r0 && r1) ? next_tie : r1;
        next_tie = !w;
        return w;
    endfunction

    // Wait for the next ack or done; kind 0=ack, 1=done, 2=timeout.
    task automatic wait_evt(output int kind, output int who, output int cyc);
        kind = 2;
        who  = 0;
        cyc  = 0;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            chk("excl", int'({ack0 & ack1, done0 & done1}), 0);
            if (ack0 || ack1 || done0 || done1) begin
                kind = (ack0 || ack1) ? 0 : 1;
                who  = (ack1 || done1) ? 1 : 0;
                cyc  = i;
                break;
            end
        end
    endtask

    task automatic expect_evt(input string tag, input int ek, input int ew,
                              input int ec);
        int k, w, c;
        wait_evt(k, w, c);
        chk({tag, "_kind"}, k, ek);
        chk({tag, "_who"}, w, ew);
        chk({tag, "_cyc"}, c, ec);
    endtask

    task automatic do_reset();
        @(negedge clk);
        clr = 1'b1;
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_outs", int'({ack0, ack1, done0, done1, sq_start}), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_sq_a", int'(sq_a), 0);
        @(negedge clk);
        clr = 1'b0;
        next_tie = 1'b0;
    endtask

    initial begin
        bit          w;
        int          ack_t;
        int          prev_ack;
        bit          seen;
        logic [7:0]  ra;
        bit          r0, r1;

        // 1: reset state
        do_reset();

        // 2: single request from requester 0
        req0 = 1'b1;
        a0   = 8'd144;
        w = model_grant(1'b1, 1'b0);
        expect_evt("t2_ack", 0, int'(w), 1);
        chk("t2_start", int'(sq_start), 1);
        chk("t2_sq_a", int'(sq_a), 144);
        req0 = 1'b0;
        expect_evt("t2_done", 1, 0, 41);
        chk("t2_result", int'(result), 12);

        // 3: simultaneous requests after reset, dropped on ack
        do_reset();
        req0 = 1'b1; a0 = 8'd255;
        req1 = 1'b1; a1 = 8'd16;
        w = model_grant(1'b1, 1'b1);
        expect_evt("t3_ack_a", 0, int'(w), 1);
        chk("t3_sq_a_a", int'(sq_a), 255);
        req0 = 1'b0;
        expect_evt("t3_done_a", 1, 0, 41);
        chk("t3_result_a", int'(result), 15);
        w = model_grant(1'b0, 1'b1);
        expect_evt("t3_ack_b", 0, int'(w), 2);
        chk("t3_sq_a_b", int'(sq_a), 16);
        req1 = 1'b0;
        expect_evt("t3_done_b", 1, 1, 41);
        chk("t3_result_b", int'(result), 4);

        // 4: both held for four grants with random operands
        a0 = 8'($urandom);
        a1 = 8'($urandom);
        req0 = 1'b1;
        req1 = 1'b1;
        prev_ack = 0;
        for (int g = 0; g < 4; g++) begin
            w = model_grant(1'b1, 1'b1);
            chk("t4_order", int'(w), g % 2);
            expect_evt("t4_ack", 0, int'(w), 2);
            ack_t = cyc_cnt;
            if (g > 0) chk("t4_period", ack_t - prev_ack, 43);
            prev_ack = ack_t;
            if (g == 3) begin
                req0 = 1'b0;
                req1 = 1'b0;
            end
            expect_evt("t4_done", 1, int'(w), 41);
            chk("t4_result", int'(result), int'(ref_isqrt(w ? a1 : a0)));
        end

        // randomized request patterns
        for (int n = 0; n < 8; n++) begin
            r0 = 1'($urandom);
            r1 = 1'($urandom);
            if (!r0 && !r1) r0 = 1'b1;
            a0 = 8'($urandom);
            a1 = 8'($urandom);
            req0 = r0;
            req1 = r1;
            w = model_grant(r0, r1);
            ra = w ? a1 : a0;
            expect_evt("rnd_ack", 0, int'(w), 2);
            chk("rnd_sq_a", int'(sq_a), int'(ra));
            req0 = 1'b0;
            req1 = 1'b0;
            a0 = ~a0;
            a1 = ~a1;
            expect_evt("rnd_done", 1, int'(w), 41);
            chk("rnd_result", int'(result), int'(ref_isqrt(ra)));
        end

        // 5: zero operand, operand changed after grant
        req1 = 1'b1;
        a1 = 8'd0;
        w = model_grant(1'b0, 1'b1);
        expect_evt("t5_ack", 0, int'(w), 2);
        req1 = 1'b0;
        a1 = 8'd200;
        for (int i = 1; i <= 41; i++) begin
            @(negedge clk);
            chk("t5_sq_a_hold", int'(sq_a), 0);
        end
        chk("t5_done1", int'(done1), 1);
        chk("t5_result", int'(result), 0);

        // 6: clear during WAIT at counter 10
        req0 = 1'b1;
        a0 = 8'd100;
        w = model_grant(1'b1, 1'b0);
        expect_evt("t6_ack", 0, int'(w), 2);
        req0 = 1'b0;
        repeat (11) @(negedge clk);
        chk("t6_busy_pre", int'(busy), 1);
        clr = 1'b1;
        #1;
        chk("t6_busy_clr", int'(busy), 0);
        chk("t6_outs_clr", int'({ack0, ack1, done0, done1, sq_start}), 0);
        @(negedge clk);
        clr = 1'b0;
        next_tie = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done0 || done1 || busy) seen = 1'b1;
        end
        chk("t6_no_done", int'(seen), 0);
        req0 = 1'b1;
        a0 = 8'd49;
        w = model_grant(1'b1, 1'b0);
        expect_evt("t6_ack2", 0, int'(w), 1);
        req0 = 1'b0;
        expect_evt("t6_done2", 1, 0, 41);
        chk("t6_result", int'(result), 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
